// File: rtl/shift_pass_sequencer.sv
// Splits one large shift request into successive passes through a combinational
// n-bit shifter. Optional abort input: define SHIFT_PASS_SEQ_ABORT_EN.
//
// state | meaning
// IDLE  | ready for a request, shifter word parked at zero
// RUN   | one shifter pass per cycle, result looped back into acc
// DONE  | response held until resp_ready
module shift_pass_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [AMT_W-1:0] req_amt,
    input  logic             req_dir,
    input  logic             req_fill,
    output logic [WIDTH-1:0] sh_in,
    output logic [WIDTH-1:0] sh_shift,
    input  logic [WIDTH-1:0] sh_out,
    input  logic [WIDTH-1:0] sh_overflow,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [WIDTH-1:0] resp_overflow,
    output logic [AMT_W-1:0] resp_passes,
    output logic             busy
`ifdef SHIFT_PASS_SEQ_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int STEP_W   = WIDTH - 2;
    localparam int STEP_CAP = (2 ** (WIDTH - 2)) - 1;
    localparam int MAX_STEP = (STEP_CAP < WIDTH - 1) ? STEP_CAP : WIDTH - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] ovf;
    logic [AMT_W-1:0] passes;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] rem_next;
    logic             dir_q;
    logic             fill_q;

    function automatic logic [AMT_W-1:0] step_of(input logic [AMT_W-1:0] r);
        if (int'(r) > MAX_STEP)
            return AMT_W'(MAX_STEP);
        else
            return r;
    endfunction

    function automatic logic [WIDTH-1:0] word_of(input logic f,
                                                 input logic [AMT_W-1:0] s,
                                                 input logic d);
        return {f, STEP_W'(s), d};
    endfunction

    always_comb begin
        rem_next = remaining - step_of(remaining);
    end

    assign sh_in         = acc;
    assign resp_data     = acc;
    assign resp_overflow = ovf;
    assign resp_passes   = passes;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            acc        <= '0;
            ovf        <= '0;
            passes     <= '0;
            remaining  <= '0;
            dir_q      <= 1'b0;
            fill_q     <= 1'b0;
            sh_shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        acc       <= req_data;
                        remaining <= req_amt;
                        dir_q     <= req_dir;
                        fill_q    <= req_fill;
                        ovf       <= '0;
                        passes    <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_amt == '0) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            sh_shift   <= '0;
                        end else begin
                            state    <= RUN;
                            sh_shift <= word_of(req_fill, step_of(req_amt), req_dir);
                        end
                    end
                end
                RUN: begin
                    acc       <= sh_out;
                    ovf       <= ovf | sh_overflow;
                    remaining <= rem_next;
                    passes    <= passes + AMT_W'(1);
                    if (rem_next == '0) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        sh_shift   <= '0;
                    end else begin
                        sh_shift <= word_of(fill_q, step_of(rem_next), dir_q);
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    req_ready  <= 1'b1;
                    sh_shift   <= '0;
                end
            endcase
`ifdef SHIFT_PASS_SEQ_ABORT_EN
            // Abort overrides whatever the case above scheduled; the partial result is dropped.
            if (abort && state != IDLE) begin
                state      <= IDLE;
                resp_valid <= 1'b0;
                busy       <= 1'b0;
                req_ready  <= 1'b1;
                sh_shift   <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_shift_pass_sequencer.sv
// Directed bench for shift_pass_sequencer at WIDTH=8 with a behavioural shifter on sh_*.
module tb_shift_pass_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_data = 8'h00;
    logic [3:0] req_amt = 4'd0;
    logic       req_dir = 1'b0;
    logic       req_fill = 1'b0;
    logic [7:0] sh_in;
    logic [7:0] sh_shift;
    logic [7:0] sh_out;
    logic [7:0] sh_overflow;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [7:0] resp_data;
    logic [7:0] resp_overflow;
    logic [3:0] resp_passes;
    logic       busy;
`ifdef SHIFT_PASS_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif

    shift_pass_sequencer #(.WIDTH(8), .AMT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_amt(req_amt), .req_dir(req_dir), .req_fill(req_fill),
        .sh_in(sh_in), .sh_shift(sh_shift), .sh_out(sh_out), .sh_overflow(sh_overflow),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_overflow(resp_overflow), .resp_passes(resp_passes), .busy(busy)
`ifdef SHIFT_PASS_SEQ_ABORT_EN
        , .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural shifter: dir=0 left, dir=1 right, fill bit shifted in, lost bits on overflow.
    logic [7:0] m_out, m_ovf;
    logic       inj = 1'b0;
    int         s;
    always_comb begin
        s     = int'(sh_shift[6:1]);
        m_out = sh_in;
        m_ovf = 8'h00;
        if (s > 8) s = 8;
        if (s != 0) begin
            if (!sh_shift[0]) begin
                m_out = sh_in << s;
                if (sh_shift[7]) m_out = m_out | (8'hFF >> (8 - s));
                m_ovf = sh_in >> (8 - s);
            end else begin
                m_out = sh_in >> s;
                if (sh_shift[7]) m_out = m_out | ~(8'hFF >> s);
                m_ovf = sh_in & ~(8'hFF << s);
            end
        end
    end
    assign sh_out      = m_out;
    assign sh_overflow = m_ovf | ((inj && sh_shift == 8'h0E) ? 8'h01 : 8'h00);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [7:0] words[$];
    int         lat;

    task automatic issue(input logic [7:0] d, input logic [3:0] a, input logic dr, input logic fl);
        @(negedge clk);
        req_valid = 1'b1; req_data = d; req_amt = a; req_dir = dr; req_fill = fl;
        @(posedge clk); #1;
        req_valid = 1'b0;
        words.delete();
        lat = 0;
        while (!resp_valid && lat < 40) begin
            words.push_back(sh_shift);
            @(posedge clk); #1;
            lat++;
        end
        check("resp_valid_rise", {7'b0, resp_valid}, 8'h01);
    endtask

    task automatic complete();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_valid_drop", {7'b0, resp_valid}, 8'h00);
        check("req_ready_after", {7'b0, req_ready}, 8'h01);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [3:0] amt;
        logic       dir;
        logic       fill;
        logic [7:0] exp_data;
        logic [7:0] exp_ovf;
        logic [3:0] exp_passes;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'hA5, 4'd0,  1'b0, 1'b0, 8'hA5, 8'h00, 4'd0};
        vecs[1] = '{8'h01, 4'd10, 1'b0, 1'b0, 8'h00, 8'h04, 4'd2};
        vecs[2] = '{8'hF0, 4'd7,  1'b1, 1'b1, 8'hFF, 8'h70, 4'd1};
        vecs[3] = '{8'h3C, 4'd3,  1'b0, 1'b1, 8'hE7, 8'h01, 4'd1};
        vecs[4] = '{8'h81, 4'd15, 1'b1, 1'b0, 8'h00, 8'h01, 4'd3};
        vecs[5] = '{8'h5A, 4'd8,  1'b0, 1'b0, 8'h00, 8'h2D, 4'd2};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_req_ready", {7'b0, req_ready}, 8'h01);
        check("rst_resp_valid", {7'b0, resp_valid}, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        check("rst_sh_shift", sh_shift, 8'h00);
        check("rst_resp_data", resp_data, 8'h00);
        check("rst_resp_passes", {4'b0, resp_passes}, 8'h00);

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].data, vecs[i].amt, vecs[i].dir, vecs[i].fill);
            check("vec_latency", 8'(lat), {4'b0, vecs[i].exp_passes});
            check("vec_data", resp_data, vecs[i].exp_data);
            check("vec_ovf", resp_overflow, vecs[i].exp_ovf);
            check("vec_passes", {4'b0, resp_passes}, {4'b0, vecs[i].exp_passes});
            check("vec_done_req_ready", {7'b0, req_ready}, 8'h00);
            check("vec_done_sh_shift", sh_shift, 8'h00);
            if (i == 1) begin
                check("split_words_n", 8'(words.size()), 8'd2);
                if (words.size() == 2) begin
                    check("split_word0", words[0], 8'h0E);
                    check("split_word1", words[1], 8'h06);
                end
            end
            if (i == 2 && words.size() > 0) check("encode_word", words[0], 8'h8F);
            complete();
        end

        // Sticky overflow: only the first pass reports overflow.
        inj = 1'b1;
        issue(8'h00, 4'd10, 1'b0, 1'b0);
        inj = 1'b0;
        check("sticky_ovf", resp_overflow, 8'h01);
        check("sticky_passes", {4'b0, resp_passes}, 8'h02);
        complete();

        // Backpressure with an ignored request pulse.
        issue(8'h3C, 4'd3, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = (c == 2);
            req_data = 8'h11; req_amt = 4'd0;
            @(posedge clk); #1;
            check("bp_valid", {7'b0, resp_valid}, 8'h01);
            check("bp_data", resp_data, 8'hE7);
            check("bp_ovf", resp_overflow, 8'h01);
            check("bp_passes", {4'b0, resp_passes}, 8'h01);
            check("bp_req_ready", {7'b0, req_ready}, 8'h00);
        end
        req_valid = 1'b0;
        complete();
        issue(8'h01, 4'd1, 1'b0, 1'b0);
        check("post_bp_latency", 8'(lat), 8'd1);
        check("post_bp_data", resp_data, 8'h02);
        complete();

        // Reset during the second RUN cycle.
        @(negedge clk);
        req_valid = 1'b1; req_data = 8'hFF; req_amt = 4'd14; req_dir = 1'b0; req_fill = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rr_busy_before", {7'b0, busy}, 8'h01);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rr_req_ready", {7'b0, req_ready}, 8'h01);
        check("rr_resp_valid", {7'b0, resp_valid}, 8'h00);
        check("rr_busy", {7'b0, busy}, 8'h00);
        check("rr_resp_data", resp_data, 8'h00);
        check("rr_sh_shift", sh_shift, 8'h00);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("rr_no_resp", {7'b0, resp_valid}, 8'h00);
        end

`ifdef SHIFT_PASS_SEQ_ABORT_EN
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("ab_idle_ready", {7'b0, req_ready}, 8'h01);
        @(negedge clk);
        req_valid = 1'b1; req_data = 8'hFF; req_amt = 4'd14;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("ab_busy_before", {7'b0, busy}, 8'h01);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("ab_req_ready", {7'b0, req_ready}, 8'h01);
        check("ab_resp_valid", {7'b0, resp_valid}, 8'h00);
        check("ab_busy", {7'b0, busy}, 8'h00);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("ab_no_resp", {7'b0, resp_valid}, 8'h00);
        end
        issue(8'h01, 4'd1, 1'b0, 1'b0);
        check("ab_recover_data", resp_data, 8'h02);
        complete();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
